// File: rtl/carfield_addr_map_pkg.sv
// carfield_addr_map_pkg: shared rule, opcode and FSM types for the runtime-programmable address map.
package carfield_addr_map_pkg;

  localparam int unsigned AddrWidthDefault = 48;

  typedef struct packed {
    logic [AddrWidthDefault-1:0] base;
    logic [AddrWidthDefault-1:0] size;
    logic                        en;
  } rule_t;

  typedef enum logic [2:0] {
    OP_WR_BASE = 3'd0,
    OP_WR_SIZE = 3'd1,
    OP_WR_EN   = 3'd2,
    OP_COMMIT  = 3'd3,
    OP_LOCK    = 3'd4
  } cfg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_CHECK
  } state_e;

endpackage

// File: rtl/carfield_addr_map_match.sv
// carfield_addr_map_match: combinational lowest-index-wins matcher over a rule table.
module carfield_addr_map_match
  import carfield_addr_map_pkg::*;
#(
  parameter int unsigned NumRules = 8,
  parameter int unsigned IdxWidth = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  rule_t [NumRules-1:0]         rules,
  input  logic  [AddrWidthDefault-1:0] addr,
  output logic  [IdxWidth-1:0]         idx,
  output logic                         hit,
  output logic                         multi
);

  logic [NumRules-1:0] m;

  // End bound is one bit wider so a rule reaching the top of the space cannot wrap to low addresses.
  always_comb begin
    m = '0;
    idx = '0;
    for (int i = 0; i < NumRules; i++)
      m[i] = rules[i].en && (|rules[i].size) && (addr >= rules[i].base) &&
             ({1'b0, addr} < ({1'b0, rules[i].base} + {1'b0, rules[i].size}));
    for (int i = NumRules - 1; i >= 0; i--)
      idx = m[i] ? IdxWidth'(i) : idx;
  end

  assign hit   = |m;
  assign multi = |(m & (m - 1'b1));

endmodule

// File: rtl/carfield_addr_map_ctrl.sv
// carfield_addr_map_ctrl: shadow/active address map with atomic commit, lock and 1-cycle lookup.
// Define CARFIELD_ADDR_MAP_OVERLAP_CHECK_EN to scan shadow rules for overlaps before each commit.
module carfield_addr_map_ctrl
  import carfield_addr_map_pkg::*;
#(
  parameter int unsigned NumRules  = 8,
  parameter int unsigned AddrWidth = AddrWidthDefault,
  parameter int unsigned IdxWidth  = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [2:0]           cfg_op_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_rsp_valid_o,
  output logic                 cfg_rsp_err_o,
  output logic                 locked_o,
  input  logic                 lk_valid_i,
  output logic                 lk_ready_o,
  input  logic [AddrWidth-1:0] lk_addr_i,
  input  logic [IdxWidth-1:0]  lk_default_idx_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [IdxWidth-1:0]  res_idx_o,
  output logic                 res_hit_o,
  output logic                 res_multi_o
);

  rule_t [NumRules-1:0] shadow_q, active_q;
  state_e               state_q;
  logic [IdxWidth-1:0]  m_idx;
  logic                 m_hit, m_multi, cfg_err;

`ifdef CARFIELD_ADDR_MAP_OVERLAP_CHECK_EN
  localparam state_e CommitEntry = (NumRules > 1) ? ST_CHECK : ST_COMMIT;
  logic [IdxWidth-1:0] pi_q, pj_q;
  logic [0:0]          a_idx, b_idx;
  logic                a_hit, b_hit, a_multi, b_multi, ov_acc_q, pair_ov, last_pair;
  // Two non-empty ranges intersect exactly when one contains the other's start address.
  carfield_addr_map_match #(.NumRules(1), .IdxWidth(1)) u_ov_a (
    .rules(shadow_q[pj_q]), .addr(shadow_q[pi_q].base), .idx(a_idx), .hit(a_hit), .multi(a_multi)
  );
  carfield_addr_map_match #(.NumRules(1), .IdxWidth(1)) u_ov_b (
    .rules(shadow_q[pi_q]), .addr(shadow_q[pj_q].base), .idx(b_idx), .hit(b_hit), .multi(b_multi)
  );
  assign pair_ov = (a_hit && shadow_q[pi_q].en && (|shadow_q[pi_q].size)) ||
                   (b_hit && shadow_q[pj_q].en && (|shadow_q[pj_q].size));
  assign last_pair = (32'(pi_q) == NumRules - 2) && (32'(pj_q) == NumRules - 1);
`else
  localparam state_e CommitEntry = ST_COMMIT;
`endif

  carfield_addr_map_match #(.NumRules(NumRules), .IdxWidth(IdxWidth)) u_match (
    .rules(active_q), .addr(lk_addr_i), .idx(m_idx), .hit(m_hit), .multi(m_multi)
  );

  assign cfg_ready_o = state_q == ST_IDLE;
  assign lk_ready_o  = (state_q == ST_IDLE) && (!res_valid_o || res_ready_i);
  assign cfg_err     = locked_o || (cfg_op_i > 3'd4) ||
                       ((cfg_op_i <= 3'd2) && (32'(cfg_idx_i) >= NumRules));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q        <= '0;
      active_q        <= '0;
      state_q         <= ST_IDLE;
      locked_o        <= 1'b0;
      cfg_rsp_valid_o <= 1'b0;
      cfg_rsp_err_o   <= 1'b0;
`ifdef CARFIELD_ADDR_MAP_OVERLAP_CHECK_EN
      pi_q            <= '0;
      pj_q            <= IdxWidth'(1);
      ov_acc_q        <= 1'b0;
`endif
    end else begin
      cfg_rsp_valid_o <= 1'b0;
      cfg_rsp_err_o   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            if (cfg_err) begin
              cfg_rsp_valid_o <= 1'b1;
              cfg_rsp_err_o   <= 1'b1;
            end else if (cfg_op_i == OP_COMMIT) begin
              state_q <= CommitEntry;
`ifdef CARFIELD_ADDR_MAP_OVERLAP_CHECK_EN
              pi_q     <= '0;
              pj_q     <= IdxWidth'(1);
              ov_acc_q <= 1'b0;
`endif
            end else begin
              cfg_rsp_valid_o <= 1'b1;
              if (cfg_op_i == OP_WR_BASE) shadow_q[cfg_idx_i].base <= cfg_wdata_i;
              if (cfg_op_i == OP_WR_SIZE) shadow_q[cfg_idx_i].size <= cfg_wdata_i;
              if (cfg_op_i == OP_WR_EN)   shadow_q[cfg_idx_i].en   <= cfg_wdata_i[0];
              if (cfg_op_i == OP_LOCK)    locked_o <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          active_q        <= shadow_q;
          cfg_rsp_valid_o <= 1'b1;
          state_q         <= ST_IDLE;
        end
`ifdef CARFIELD_ADDR_MAP_OVERLAP_CHECK_EN
        ST_CHECK: begin
          ov_acc_q <= ov_acc_q || pair_ov;
          if (last_pair) begin
            state_q         <= (ov_acc_q || pair_ov) ? ST_IDLE : ST_COMMIT;
            cfg_rsp_valid_o <= ov_acc_q || pair_ov;
            cfg_rsp_err_o   <= ov_acc_q || pair_ov;
          end else if (32'(pj_q) == NumRules - 1) begin
            pi_q <= pi_q + 1'b1;
            pj_q <= pi_q + IdxWidth'(2);
          end else begin
            pj_q <= pj_q + 1'b1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_o <= 1'b0;
      res_idx_o   <= '0;
      res_hit_o   <= 1'b0;
      res_multi_o <= 1'b0;
    end else if (lk_valid_i && lk_ready_o) begin
      res_valid_o <= 1'b1;
      res_idx_o   <= m_hit ? m_idx : lk_default_idx_i;
      res_hit_o   <= m_hit;
      res_multi_o <= m_multi;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

endmodule
